// File: rtl/la_ctrl_pkg.sv
// Shared definitions for the LA lane router: register offsets, capture FSM encoding,
// CTRL bit positions and width helpers.
package la_ctrl_pkg;

  // Byte offsets, compared against {adr[7:2], 2'b00}
  localparam logic [7:0] ADR_CTRL   = 8'h40;
  localparam logic [7:0] ADR_TMASK  = 8'h44;
  localparam logic [7:0] ADR_TVAL   = 8'h48;
  localparam logic [7:0] ADR_STATUS = 8'h4C;
  localparam logic [7:0] ADR_DATA   = 8'h50;
  localparam logic [7:0] ADR_TS     = 8'h54;

  localparam int unsigned CTRL_ARM     = 0;
  localparam int unsigned CTRL_ABORT   = 1;
  localparam int unsigned CTRL_LANE_LO = 8;

  typedef logic [1:0] cap_state_t;
  localparam cap_state_t ST_IDLE  = 2'd0;
  localparam cap_state_t ST_ARMED = 2'd1;
  localparam cap_state_t ST_CAPT  = 2'd2;
  localparam cap_state_t ST_DONE  = 2'd3;

  function automatic int unsigned lane_w(input int unsigned la_width, input int unsigned lanes);
    return la_width / lanes;
  endfunction

  function automatic int unsigned sel_w(input int unsigned num_teams);
    return $clog2(num_teams + 1);
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] sel);
    logic [31:0] r;
    for (int unsigned b = 0; b < 4; b++)
      r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

endpackage

// File: rtl/la_capture_buf.sv
// DEPTH x W capture register file: linear write count that saturates at DEPTH,
// read pointer that wraps modulo DEPTH.
module la_capture_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     wr_cnt,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic         wr_ok;

  // A full buffer never wraps, so earlier samples are not overwritten
  assign wr_ok = wr_en && (wr_cnt < (AW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_cnt[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_cnt <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/la_lane_mux_capture.sv
// Wishbone-controlled per-lane LA router with a triggered capture engine.
// Optional macro LA_CAP_TIMESTAMP_EN adds a free-running trigger timestamp (TS register).
module la_lane_mux_capture
  import la_ctrl_pkg::*;
#(
  parameter int unsigned NUM_TEAMS = 12,
  parameter int unsigned LA_WIDTH  = 128,
  parameter int unsigned LANES     = 4,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_i,
  input  logic                                wbs_stb_i,
  input  logic                                wbs_cyc_i,
  input  logic                                wbs_we_i,
  input  logic [3:0]                          wbs_sel_i,
  input  logic [31:0]                         wbs_dat_i,
  input  logic [31:0]                         wbs_adr_i,
  output logic                                wbs_ack_o,
  output logic [31:0]                         wbs_dat_o,
  input  logic [LA_WIDTH*(NUM_TEAMS+1)-1:0]   designs_la_data_out_flat,
  output logic [LA_WIDTH-1:0]                 la_data_out,
  output logic                                irq_o
);
  localparam int unsigned LANE_W = lane_w(LA_WIDTH, LANES);
  localparam int unsigned SEL_W  = sel_w(NUM_TEAMS);
  localparam int unsigned AW     = $clog2(DEPTH);

  logic [SEL_W-1:0]  lsel [LANES];
  logic [LANE_W-1:0] lane_nxt [LANES];
  logic [LANE_W-1:0] tmask, tval, sample, buf_rd_data;
  logic [1:0]        cap_lane;
  cap_state_t        state;
  logic              req, wr_op, rd_op, ctrl_wr, arm, abort, trig;
  logic              buf_wr, buf_rd;
  logic [7:0]        word_adr;
  logic [31:0]       rdata, ts_rd;
  logic [AW:0]       wr_cnt;
  logic [AW-1:0]     rd_ptr;
  logic              unused_adr;

  assign unused_adr = ^{wbs_adr_i[31:8], wbs_adr_i[1:0]};

  assign req      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
  assign wr_op    = req & wbs_we_i;
  assign rd_op    = req & ~wbs_we_i;
  assign word_adr = {wbs_adr_i[7:2], 2'b00};
  assign ctrl_wr  = wr_op && (word_adr == ADR_CTRL);
  assign abort    = ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_ABORT];
  assign arm      = ctrl_wr && wbs_sel_i[0] && wbs_dat_i[CTRL_ARM] && !abort;
  assign buf_rd   = rd_op && (word_adr == ADR_DATA);

  // Sources past NUM_TEAMS match no comparison and leave the lane at zero
  always_comb begin
    for (int unsigned n = 0; n < LANES; n++) begin
      lane_nxt[n] = '0;
      for (int unsigned d = 0; d <= NUM_TEAMS; d++)
        if (lsel[n] == SEL_W'(d))
          lane_nxt[n] = designs_la_data_out_flat[LA_WIDTH*d + LANE_W*n +: LANE_W];
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) la_data_out <= '0;
    else for (int unsigned n = 0; n < LANES; n++) la_data_out[LANE_W*n +: LANE_W] <= lane_nxt[n];
  end

  always_comb begin
    sample = '0;
    for (int unsigned n = 0; n < LANES; n++)
      if (32'(cap_lane) == n) sample = la_data_out[LANE_W*n +: LANE_W];
  end

  assign trig   = ((sample ^ tval) & tmask) == '0;
  assign buf_wr = !arm && !abort && (((state == ST_ARMED) && trig) || (state == ST_CAPT));

  always_comb begin
    rdata = '0;
    for (int unsigned n = 0; n < LANES; n++)
      if (wbs_adr_i[7:2] == 6'(n)) rdata = 32'(lsel[n]);
    case (word_adr)
      ADR_TMASK:  rdata = 32'(tmask);
      ADR_TVAL:   rdata = 32'(tval);
      ADR_STATUS: rdata = {8'(cap_lane), 8'(rd_ptr), 8'(wr_cnt), 6'd0, state};
      ADR_DATA:   rdata = 32'(buf_rd_data);
      ADR_TS:     rdata = ts_rd;
      default:    ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      tmask     <= '0;
      tval      <= '0;
      cap_lane  <= '0;
      for (int unsigned n = 0; n < LANES; n++) lsel[n] <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_op ? rdata : '0;
      if (wr_op) begin
        for (int unsigned n = 0; n < LANES; n++)
          if (wbs_adr_i[7:2] == 6'(n))
            lsel[n] <= SEL_W'(be_merge(32'(lsel[n]), wbs_dat_i, wbs_sel_i));
        if (word_adr == ADR_TMASK) tmask <= LANE_W'(be_merge(32'(tmask), wbs_dat_i, wbs_sel_i));
        if (word_adr == ADR_TVAL)  tval  <= LANE_W'(be_merge(32'(tval), wbs_dat_i, wbs_sel_i));
        if (ctrl_wr && wbs_sel_i[1]) cap_lane <= wbs_dat_i[CTRL_LANE_LO +: 2];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      irq_o <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      irq_o <= 1'b0;
    end else if (arm) begin
      state <= ST_ARMED;
      irq_o <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: if (trig) state <= ST_CAPT;
        ST_CAPT: if (wr_cnt == (AW+1)'(DEPTH-1)) begin
          state <= ST_DONE;
          irq_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  la_capture_buf #(.DEPTH(DEPTH), .W(LANE_W)) u_buf (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .clr     (arm),
    .wr_en   (buf_wr),
    .wr_data (sample),
    .rd_en   (buf_rd),
    .rd_data (buf_rd_data),
    .wr_cnt  (wr_cnt),
    .rd_ptr  (rd_ptr)
  );

`ifdef LA_CAP_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_lat;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (arm) ts_lat <= '0;
      else if (!abort && (state == ST_ARMED) && trig) ts_lat <= ts_cnt;
    end
  end

  assign ts_rd = ts_lat;
`else
  assign ts_rd = '0;
`endif

endmodule

// File: tb/tb_la_lane_mux_capture.sv
// Directed bench for la_lane_mux_capture: routing, capture, abort, re-arm, byte enables, TS.
module tb_la_lane_mux_capture;
  localparam int unsigned NT = 12;
  localparam int unsigned LW = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              stb, cyc, we;
  logic [3:0]        sel;
  logic [31:0]       dat_i, adr;
  logic              ack;
  logic [31:0]       dat_o;
  logic [LW*(NT+1)-1:0] flat;
  logic [LW-1:0]     la_out;
  logic              irq;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  la_lane_mux_capture #(.NUM_TEAMS(NT), .LA_WIDTH(LW), .LANES(4), .DEPTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .designs_la_data_out_flat(flat), .la_data_out(la_out), .irq_o(irq)
  );

`ifdef LA_CAP_TIMESTAMP_EN
  logic [31:0] tb_cyc;
  always @(posedge clk) if (rst) tb_cyc <= '0; else tb_cyc <= tb_cyc + 1;
`endif

  task automatic set_lane(input int unsigned d, input int unsigned l, input logic [31:0] v);
    flat[LW*d + 32*l +: 32] = v;
  endtask

  task automatic wait_ack(output logic [31:0] rd);
    int unsigned k = 0;
    do begin @(negedge clk); k++; end while (!ack && k < 8);
    rd = dat_o;
    if (!ack) begin
      n_vec++; n_err++;
      $display("FAIL ack_timeout adr=%h got no ack, need ack within 8 cycles", adr);
    end
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] unused_rd;
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = {24'd0, a}; dat_i = d; sel = s;
    wait_ack(unused_rd);
  endtask

  task automatic wb_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = {24'd0, a}; sel = 4'hF;
    wait_ack(d);
  endtask

  task automatic test_reset;
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (la_out !== '0) begin n_err++; $display("FAIL rst_la got=%h need=0", la_out); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got=%b need=0", irq); end
    n_vec++; if ({ack, dat_o} !== 33'd0) begin n_err++; $display("FAIL rst_wb got=%h need=0", {ack, dat_o}); end
    rst = 1'b0;
    wb_read(8'h00, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rst_lsel0 got=%h need=0", r); end
    @(negedge clk);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL ack_one_cycle got=%b need=0", ack); end
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rst_status got=%h need=0", r); end
    wb_read(8'h40, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ctrl_read got=%h need=0", r); end
  endtask

  task automatic test_lane_routing;
    logic [31:0] r;
    for (int unsigned d = 0; d <= NT; d++)
      for (int unsigned l = 0; l < 4; l++) set_lane(d, l, 32'h1000_0000 | (d << 8) | l);
    wb_write(8'h00, 32'd3, 4'hF);
    wb_write(8'h04, 32'd12, 4'hF);
    wb_write(8'h08, 32'd13, 4'hF);
    repeat (2) @(negedge clk);
    n_vec++; if (la_out !== {32'h1000_0003, 32'h0, 32'h1000_0C01, 32'h1000_0300}) begin
      n_err++; $display("FAIL route_pattern got=%h", la_out); end
    set_lane(3, 0, 32'hA5A5_A5A5);
    set_lane(12, 1, 32'h1234_5678);
    #1;
    n_vec++; if (la_out[31:0] !== 32'h1000_0300) begin
      n_err++; $display("FAIL mux_latency got=%h need=10000300", la_out[31:0]); end
    @(negedge clk);
    n_vec++; if (la_out !== {32'h1000_0003, 32'h0, 32'h1234_5678, 32'hA5A5_A5A5}) begin
      n_err++; $display("FAIL route_new got=%h", la_out); end
    wb_read(8'h08, r);
    n_vec++; if (r !== 32'd13) begin n_err++; $display("FAIL lsel2_rb got=%h need=d", r); end
    wb_write(8'h0C, 32'd5, 4'h0);
    wb_read(8'h0C, r);
    n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL lsel_sel0 got=%h need=0", r); end
  endtask

  task automatic test_capture;
    logic [31:0] r;
    set_lane(3, 0, 32'hABCD_0030);
    wb_write(8'h44, 32'hFF, 4'hF);
    wb_write(8'h48, 32'h40, 4'hF);
    wb_write(8'h40, 32'h1, 4'h3);
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge clk);
      set_lane(3, 0, 32'hABCD_0031 + i);
    end
    n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL cap_irq got=%b need=1", irq); end
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0000_1003) begin n_err++; $display("FAIL cap_status got=%h need=00001003", r); end
    for (int unsigned i = 0; i < 17; i++) begin
      wb_read(8'h50, r);
      n_vec++; if (r !== 32'hABCD_0040 + (i % 16)) begin
        n_err++; $display("FAIL cap_data[%0d] got=%h need=%h", i, r, 32'hABCD_0040 + (i % 16)); end
    end
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0001_1003) begin n_err++; $display("FAIL cap_status_rd got=%h need=00011003", r); end
  endtask

  task automatic test_abort;
    logic [31:0] r;
    set_lane(3, 0, 32'h0);
    wb_write(8'h40, 32'h1, 4'h3);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL armed_status got=%h need=1", r); end
    n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL arm_irq_clr got=%b need=0", irq); end
    wb_write(8'h40, 32'h2, 4'h1);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL abort_status got=%h need=0", r); end
    wb_read(8'h50, r);
    n_vec++; if (r !== 32'hABCD_0040) begin n_err++; $display("FAIL abort_retain got=%h need=abcd0040", r); end
    wb_write(8'h40, 32'h1, 4'h3);
    wb_write(8'h40, 32'h3, 4'h3);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL arm_abort_prec got=%h need=0", r); end
    wb_write(8'h40, 32'h1, 4'h2);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ctrl_sel0_off got=%h need=0", r); end
  endtask

  task automatic test_rearm;
    logic [31:0] r;
    wb_write(8'h44, 32'h0, 4'hF);
    wb_write(8'h40, 32'h1, 4'h3);
    wb_read(8'h4C, r);
    n_vec++; if (r[1:0] !== 2'd2) begin n_err++; $display("FAIL capt_state got=%0d need=2", r[1:0]); end
    wb_read(8'h50, r);
    wb_write(8'h44, 32'hFF, 4'hF);
    wb_write(8'h40, 32'h1, 4'h3);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h1) begin n_err++; $display("FAIL rearm_status got=%h need=1", r); end
    wb_write(8'h44, 32'hFFFF_FF7F, 4'b0001);
    wb_read(8'h44, r);
    n_vec++; if (r !== 32'h7F) begin n_err++; $display("FAIL tmask_be got=%h need=7f", r); end
  endtask

  task automatic test_cap_lane;
    logic [31:0] r;
    wb_write(8'h44, 32'hFFFF_FFFF, 4'hF);
    wb_write(8'h48, 32'h1234_5678, 4'hF);
    wb_write(8'h40, 32'h101, 4'h3);
    repeat (24) @(negedge clk);
    wb_read(8'h4C, r);
    n_vec++; if (r !== 32'h0100_1003) begin n_err++; $display("FAIL lane1_status got=%h need=01001003", r); end
    wb_read(8'h50, r);
    n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL lane1_data got=%h need=12345678", r); end
  endtask

  task automatic test_unmapped;
    logic [31:0] r;
    wb_write(8'h60, 32'hDEAD_BEEF, 4'hF);
    wb_read(8'h60, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL unmapped got=%h need=0", r); end
    wb_read(8'h48, r);
    n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL tval_kept got=%h need=12345678", r); end
  endtask

  task automatic test_timestamp;
    logic [31:0] r;
`ifdef LA_CAP_TIMESTAMP_EN
    logic [31:0] n_ts;
    set_lane(3, 0, 32'h0);
    wb_write(8'h48, 32'h5A5A_5A5A, 4'hF);
    wb_write(8'h40, 32'h001, 4'h3);
    wb_read(8'h54, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ts_arm_clr got=%h need=0", r); end
    @(negedge clk); set_lane(3, 0, 32'h5A5A_5A5A);
    @(negedge clk); n_ts = tb_cyc; set_lane(3, 0, 32'h0);
    repeat (3) @(negedge clk);
    wb_read(8'h54, r);
    n_vec++; if (r !== n_ts) begin n_err++; $display("FAIL ts_value got=%h need=%h", r, n_ts); end
`else
    wb_read(8'h54, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL ts_disabled got=%h need=0", r); end
`endif
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0; adr = '0; flat = '0;
    test_reset;
    test_lane_routing;
    test_capture;
    test_abort;
    test_rearm;
    test_cap_lane;
    test_unmapped;
    test_timestamp;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/la_lane_mux_capture.md
Name: la_lane_mux_capture

Overview:
- Wishbone-controlled logic-analyzer router for NUM_TEAMS+1 designs. Each 128-bit LA bus is split into LANES independent lanes, and each lane selects its source design separately.
- Adds a triggered capture engine. Software arms it, and it records DEPTH consecutive samples of one selected lane into a buffer readable over Wishbone.
- Sits between the per-team LA buses and the caravel LA output, replacing the single whole-bus selector.

Parameters:
- NUM_TEAMS, 12, number of team designs; source index range is 0..NUM_TEAMS.
- LA_WIDTH, 128, LA bus width per design.
- LANES, 4, number of independently muxed lanes; LANE_W = LA_WIDTH/LANES, constrained to LANE_W <= 32.
- DEPTH, 16, capture buffer entries (power of 2, >= 2).

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous active-high reset
- wbs_stb_i  in  1  Wishbone strobe
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte enables
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  address; only [7:2] are decoded
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- designs_la_data_out_flat  in  LA_WIDTH*(NUM_TEAMS+1)  design d occupies bits [LA_WIDTH*d +: LA_WIDTH]
- la_data_out  out  LA_WIDTH  muxed LA bus
- irq_o  out  1  capture-done interrupt (level)

Behaviour:
- Clocking and reset: one clock, wb_clk_i. Reset is synchronous, active-high, on wb_rst_i. Every register and output clears on reset: la_data_out=0, ack=0, dat_o=0, irq_o=0, all lane selects=0, mask=0, value=0, FSM=IDLE, pointers=0.
- Register map (word offsets on adr[7:0]):
  - 0x00+4n: LSEL[n], n<LANES, ceil(log2(NUM_TEAMS+1)) bits, read/write.
  - 0x40: CTRL, write-only. bit0 ARM, bit1 ABORT, bits[9:8] CAP_LANE. Reads return 0.
  - 0x44: TMASK, LANE_W bits, read/write.
  - 0x48: TVAL, LANE_W bits, read/write.
  - 0x4C: STATUS, read-only. [1:0] state, [15:8] wr count, [23:16] rd ptr, [31:24] CAP_LANE.
  - 0x50: DATA, read-pop of the buffer.
  - 0x54: TS (optional feature).
  - Unmapped addresses read 0; writes to them are ignored.
- Wishbone handshake:
  - ack asserts exactly 1 cycle after a cycle with stb&cyc&!ack, for exactly 1 cycle.
  - dat_o is valid in the same cycle as ack.
  - Writes commit on the ack cycle.
  - Byte enables apply to LSEL/TMASK/TVAL. For CTRL, only sel[0] and sel[1] are honoured.
- Lane mux:
  - la_data_out[n*LANE_W +: LANE_W] is registered from source design LSEL[n].
  - Latency is 1 cycle from the input change.
  - A new LSEL value takes effect on the second edge after its write commits.
  - An out-of-range LSEL (> NUM_TEAMS) drives that lane to 0.
- Capture FSM, encoded IDLE=0, ARMED=1, CAPT=2, DONE=3:
  - Sampled data is the registered lane CAP_LANE (after the mux). CAP_LANE >= LANES captures 0.
  - Trigger condition: (sample & TMASK) == (TVAL & TMASK). TMASK=0 triggers on the first ARMED cycle.
  - ARM from any state: clear wr/rd pointers, clear irq_o, go to ARMED.
  - ARMED: on trigger, write the sample to buf[0], set wr=1, go to CAPT.
  - CAPT: write buf[wr] every cycle. When wr reaches DEPTH, go to DONE.
  - DONE: set irq_o=1 and hold until ARM or ABORT. No wrap and no overwrite.
  - ABORT: go to IDLE and clear irq_o. Buffer contents are retained.
  - ARM and ABORT written in the same cycle: ABORT wins.
  - Reset mid-capture: immediate IDLE, pointers 0.
- Buffer readback:
  - A DATA read returns buf[rd] (zero-extended) and then increments rd, wrapping mod DEPTH.
  - DATA reads are allowed in any state. A read before DONE returns the current contents, which are undefined before the first capture.

Optional Feature:
- Macro: LA_CAP_TIMESTAMP_EN.
- When defined:
  - A 32-bit free-running counter runs from reset.
  - Its value is latched on the trigger cycle.
  - TS reads the latched value.
  - ARM clears the latched value to 0.
- When undefined: TS reads 0, and no counter logic is generated.

Decomposition:
- Shared package la_ctrl_pkg holds:
  - register offset constants;
  - the FSM state encoding;
  - CTRL bit positions;
  - the LANE_W and select-width helper functions.
- One natural sub-module: la_capture_buf, a DEPTH x LANE_W single-write/single-read register file with write/read pointers and wrap logic.
- The lane mux and Wishbone decode stay in the top module.

Test Plan:
- Reset: then read 0x00 and 0x4C -> 0, la_data_out = 0, irq_o = 0.
- Lane routing: write LSEL0=3, LSEL1=12, LSEL2=13; drive design3 lane0 = 0xA5A5A5A5 and design12 lane1 = 0x12345678 -> la_data_out[31:0]=0xA5A5A5A5, [63:32]=0x12345678, [95:64]=0. Confirm the 1-cycle mux latency.
- Triggered capture: set TMASK=0xFF, TVAL=0x40, drive lane0 as a counter incrementing per cycle, write CTRL=ARM (CAP_LANE=0) -> state reaches DONE after 16 samples and irq_o=1. Sixteen DATA reads return 0x..40 through 0x..4F; the 17th read returns the 0x..40 sample again (wrap).
- Abort and precedence: ARM, then ABORT before the trigger -> state IDLE, irq_o=0. A single CTRL write with both ARM and ABORT set -> IDLE.
- Re-arm: re-ARM during CAPT -> pointers reset, state ARMED. Write sel=4'b0001 with data 0xFFFF_FF7F to TMASK -> only the low byte updates; TMASK reads 0x0000007F.
- Timestamp (LA_CAP_TIMESTAMP_EN defined): trigger at counter=N -> TS reads N. With the macro undefined -> TS reads 0.
